// File: rtl/dpram_rd_arbiter_if.sv
// Bundles the two burst-read requesters, the dpram read port and the tagged response stream
// seen by dpram_rd_arbiter.
interface dpram_rd_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LEN_WIDTH  = 9
);
   logic                  req0_valid;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [LEN_WIDTH-1:0]  req0_len;
   logic                  req0_ready;
   logic                  req1_valid;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [LEN_WIDTH-1:0]  req1_len;
   logic                  req1_ready;
   logic                  ram_re;
   logic [ADDR_WIDTH-1:0] ram_raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  rsp_valid;
   logic                  rsp_id;
   logic                  rsp_last;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  busy;

   modport slave (
      input  req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len, ram_rdata,
      output req0_ready, req1_ready, ram_re, ram_raddr, rsp_valid, rsp_id, rsp_last, rsp_data,
             busy
   );

   modport master (
      output req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len, ram_rdata,
      input  req0_ready, req1_ready, ram_re, ram_raddr, rsp_valid, rsp_id, rsp_last, rsp_data,
             busy
   );
endinterface

// File: rtl/dpram_rd_arbiter.sv
// Round-robin arbiter sharing one dpram read port between two burst-read requesters; a tag
// pipeline matched to the dpram read latency marks each returned word with owner and last.
module dpram_rd_arbiter #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LEN_WIDTH  = 9,
   parameter int unsigned RD_LATENCY = 2
) (
   input logic             clk,
   input logic             rst_n,
   dpram_rd_arbiter_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] cur_addr_q;
   logic [LEN_WIDTH-1:0]  remaining_q;
   logic                  owner_q;
   // Requester that wins when both are valid.
   logic                  prio_q;

   logic [RD_LATENCY-1:0] tag_valid_q;
   logic [RD_LATENCY-1:0] tag_id_q;
   logic [RD_LATENCY-1:0] tag_last_q;

   logic                  grant0;
   logic                  grant1;
   logic                  issue;
   logic                  issue_last;
   logic [DATA_WIDTH-1:0] rd_data;

   always_comb begin
      grant0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
      grant1 = bus.req1_valid && (!bus.req0_valid ||  prio_q);
   end

   assign issue      = (state_q == StBurst);
   assign issue_last = issue && (remaining_q == '0);

   assign bus.req0_ready = (state_q == StIdle) && grant0;
   assign bus.req1_ready = (state_q == StIdle) && grant1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         owner_q     <= 1'b0;
         prio_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant0 || grant1) begin
                  cur_addr_q  <= grant1 ? bus.req1_addr : bus.req0_addr;
                  remaining_q <= grant1 ? bus.req1_len  : bus.req0_len;
                  owner_q     <= grant1;
                  prio_q      <= ~grant1;
                  state_q     <= StBurst;
               end
            end
            StBurst: begin
               // Address wraps naturally at 2^ADDR_WIDTH.
               cur_addr_q  <= cur_addr_q + ADDR_WIDTH'(1);
               remaining_q <= remaining_q - LEN_WIDTH'(1);
               if (remaining_q == '0) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Shifts every cycle, like the dpram output stage, regardless of ram_re.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid_q <= '0;
         tag_id_q    <= '0;
         tag_last_q  <= '0;
      end else begin
         tag_valid_q[0] <= issue;
         tag_id_q[0]    <= issue & owner_q;
         tag_last_q[0]  <= issue_last;
         for (int i = 1; i < int'(RD_LATENCY); i++) begin
            tag_valid_q[i] <= tag_valid_q[i-1];
            tag_id_q[i]    <= tag_id_q[i-1];
            tag_last_q[i]  <= tag_last_q[i-1];
         end
      end
   end

   assign rd_data       = bus.ram_rdata;
   assign bus.rsp_data  = rd_data;
   assign bus.ram_re    = issue;
   assign bus.ram_raddr = cur_addr_q;
   assign bus.rsp_valid = tag_valid_q[RD_LATENCY-1];
   assign bus.rsp_id    = tag_id_q[RD_LATENCY-1];
   assign bus.rsp_last  = tag_last_q[RD_LATENCY-1];
   assign bus.busy      = issue || (|tag_valid_q);

endmodule

// File: tb/tb_dpram_rd_arbiter.sv
// Directed bench for dpram_rd_arbiter: one instance per legal read latency, both fed the same
// requests, each backed by a behavioural dpram holding RAM[i] = i & 0xFF.
module tb_dpram_rd_arbiter;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 8;
   localparam int unsigned LW = 9;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   dpram_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus2 ();
   dpram_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus1 ();

   dpram_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_LATENCY(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   dpram_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_LATENCY(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   assign bus1.req0_valid = bus2.req0_valid;
   assign bus1.req0_addr  = bus2.req0_addr;
   assign bus1.req0_len   = bus2.req0_len;
   assign bus1.req1_valid = bus2.req1_valid;
   assign bus1.req1_addr  = bus2.req1_addr;
   assign bus1.req1_len   = bus2.req1_len;

   // dpram models: registered output (latency 2) and plain read (latency 1).
   logic [7:0] m2_s1, m2_s2, m1_s1;
   always_ff @(posedge clk) begin
      if (bus2.ram_re) m2_s1 <= bus2.ram_raddr[7:0];
      m2_s2 <= m2_s1;
      if (bus1.ram_re) m1_s1 <= bus1.ram_raddr[7:0];
   end
   assign bus2.ram_rdata = m2_s2;
   assign bus1.ram_rdata = m1_s1;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      total++; if (bus2.ram_re !== 1'b0) begin bad++; $display("FAIL reset ram_re got=%b want=0", bus2.ram_re); end
      total++; if (bus2.ram_raddr !== 9'h000) begin bad++; $display("FAIL reset ram_raddr got=%h want=000", bus2.ram_raddr); end
      total++; if (bus2.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset rsp_valid got=%b want=0", bus2.rsp_valid); end
      total++; if (bus2.rsp_id !== 1'b0) begin bad++; $display("FAIL reset rsp_id got=%b want=0", bus2.rsp_id); end
      total++; if (bus2.rsp_last !== 1'b0) begin bad++; $display("FAIL reset rsp_last got=%b want=0", bus2.rsp_last); end
      total++; if (bus2.busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", bus2.busy); end
      total++; if ({bus2.req1_ready, bus2.req0_ready} !== 2'b00) begin bad++; $display("FAIL reset readys got=%b%b want=00", bus2.req1_ready, bus2.req0_ready); end
      total++; if (bus1.rsp_valid !== 1'b0 || bus1.busy !== 1'b0) begin bad++; $display("FAIL reset lat1 valid/busy got=%b%b want=00", bus1.rsp_valid, bus1.busy); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One burst from a lone requester; checks issue, latency, data, tags and busy on both DUTs.
   task automatic do_burst(input bit id, input logic [8:0] addr, input logic [8:0] len,
                           input string name);
      logic [8:0] a;
      logic [1:0] want_rdy;
      int n;
      bit exp_v;
      n = int'(len) + 1;
      @(negedge clk);
      if (id) begin
         bus2.req1_valid = 1'b1; bus2.req1_addr = addr; bus2.req1_len = len;
      end else begin
         bus2.req0_valid = 1'b1; bus2.req0_addr = addr; bus2.req0_len = len;
      end
      want_rdy = id ? 2'b10 : 2'b01;
      #1;
      total++; if ({bus2.req1_ready, bus2.req0_ready} !== want_rdy) begin bad++; $display("FAIL %s accept readys got=%b%b want=%b", name, bus2.req1_ready, bus2.req0_ready, want_rdy); end
      for (int c = 1; c <= n + 3; c++) begin
         @(negedge clk);
         if (c == 1) begin bus2.req0_valid = 1'b0; bus2.req1_valid = 1'b0; end
         #1;
         total++; if ({bus2.req1_ready, bus2.req0_ready} !== 2'b00) begin bad++; $display("FAIL %s extra ready c=%0d got=%b%b want=00", name, c, bus2.req1_ready, bus2.req0_ready); end
         total++; if (bus2.ram_re !== (c <= n)) begin bad++; $display("FAIL %s ram_re c=%0d got=%b want=%b", name, c, bus2.ram_re, c <= n); end
         if (c <= n) begin
            a = addr + 9'(c - 1);
            total++; if (bus2.ram_raddr !== a) begin bad++; $display("FAIL %s ram_raddr c=%0d got=%h want=%h", name, c, bus2.ram_raddr, a); end
         end
         total++; if (bus2.busy !== (c <= n + 2)) begin bad++; $display("FAIL %s busy c=%0d got=%b want=%b", name, c, bus2.busy, c <= n + 2); end
         exp_v = (c >= 3) && (c <= n + 2);
         total++; if (bus2.rsp_valid !== exp_v) begin bad++; $display("FAIL %s rsp_valid c=%0d got=%b want=%b", name, c, bus2.rsp_valid, exp_v); end
         if (exp_v) begin
            a = addr + 9'(c - 3);
            total++; if (bus2.rsp_data !== a[7:0]) begin bad++; $display("FAIL %s rsp_data c=%0d got=%h want=%h", name, c, bus2.rsp_data, a[7:0]); end
            total++; if (bus2.rsp_id !== id) begin bad++; $display("FAIL %s rsp_id c=%0d got=%b want=%b", name, c, bus2.rsp_id, id); end
            total++; if (bus2.rsp_last !== (c == n + 2)) begin bad++; $display("FAIL %s rsp_last c=%0d got=%b want=%b", name, c, bus2.rsp_last, c == n + 2); end
         end
         exp_v = (c >= 2) && (c <= n + 1);
         total++; if (bus1.rsp_valid !== exp_v) begin bad++; $display("FAIL %s lat1 rsp_valid c=%0d got=%b want=%b", name, c, bus1.rsp_valid, exp_v); end
         total++; if (bus1.busy !== (c <= n + 1)) begin bad++; $display("FAIL %s lat1 busy c=%0d got=%b want=%b", name, c, bus1.busy, c <= n + 1); end
         if (exp_v) begin
            a = addr + 9'(c - 2);
            total++; if (bus1.rsp_data !== a[7:0]) begin bad++; $display("FAIL %s lat1 rsp_data c=%0d got=%h want=%h", name, c, bus1.rsp_data, a[7:0]); end
            total++; if (bus1.rsp_id !== id) begin bad++; $display("FAIL %s lat1 rsp_id c=%0d got=%b want=%b", name, c, bus1.rsp_id, id); end
            total++; if (bus1.rsp_last !== (c == n + 1)) begin bad++; $display("FAIL %s lat1 rsp_last c=%0d got=%b want=%b", name, c, bus1.rsp_last, c == n + 1); end
         end
      end
   endtask

   task automatic test_single_burst();
      do_burst(1'b0, 9'h010, 9'd3, "single");
   endtask

   task automatic test_wrap();
      do_burst(1'b1, 9'h1FE, 9'd3, "wrap");
   endtask

   task automatic test_len_extremes();
      do_burst(1'b0, 9'h100, 9'd0, "len0");
      do_burst(1'b1, 9'h0F0, 9'd511, "len511");
   endtask

   task automatic test_contention();
      logic [8:0] base [2];
      logic [8:0] a;
      logic [1:0] want_rdy;
      int g, r;
      bit exp_v;
      base[0] = 9'h020;
      base[1] = 9'h040;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus2.req0_addr = base[0]; bus2.req0_len = 9'd1; bus2.req0_valid = 1'b1;
            bus2.req1_addr = base[1]; bus2.req1_len = 9'd1; bus2.req1_valid = 1'b1;
         end
         #1;
         g = (c / 3) % 2;
         if (c % 3 == 0) begin
            want_rdy = (g == 1) ? 2'b10 : 2'b01;
            total++; if ({bus2.req1_ready, bus2.req0_ready} !== want_rdy) begin bad++; $display("FAIL contention grant c=%0d got=%b%b want=%b", c, bus2.req1_ready, bus2.req0_ready, want_rdy); end
            total++; if (bus2.ram_re !== 1'b0) begin bad++; $display("FAIL contention bubble c=%0d ram_re got=%b want=0", c, bus2.ram_re); end
         end else begin
            a = base[g] + 9'(c % 3 - 1);
            total++; if ({bus2.req1_ready, bus2.req0_ready} !== 2'b00) begin bad++; $display("FAIL contention ready in burst c=%0d got=%b%b want=00", c, bus2.req1_ready, bus2.req0_ready); end
            total++; if (bus2.ram_re !== 1'b1) begin bad++; $display("FAIL contention ram_re c=%0d got=%b want=1", c, bus2.ram_re); end
            total++; if (bus2.ram_raddr !== a) begin bad++; $display("FAIL contention ram_raddr c=%0d got=%h want=%h", c, bus2.ram_raddr, a); end
         end
         r = c - 2;
         exp_v = (r >= 1) && (r % 3 != 0);
         total++; if (bus2.rsp_valid !== exp_v) begin bad++; $display("FAIL contention rsp_valid c=%0d got=%b want=%b", c, bus2.rsp_valid, exp_v); end
         if (exp_v) begin
            g = (r / 3) % 2;
            a = base[g] + 9'(r % 3 - 1);
            total++; if (bus2.rsp_id !== g[0]) begin bad++; $display("FAIL contention rsp_id c=%0d got=%b want=%b", c, bus2.rsp_id, g[0]); end
            total++; if (bus2.rsp_data !== a[7:0]) begin bad++; $display("FAIL contention rsp_data c=%0d got=%h want=%h", c, bus2.rsp_data, a[7:0]); end
            total++; if (bus2.rsp_last !== (r % 3 == 2)) begin bad++; $display("FAIL contention rsp_last c=%0d got=%b want=%b", c, bus2.rsp_last, r % 3 == 2); end
         end
      end
      @(negedge clk);
      bus2.req0_valid = 1'b0;
      bus2.req1_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++; if (bus2.busy !== 1'b0 || bus2.rsp_valid !== 1'b0) begin bad++; $display("FAIL contention drain busy/valid got=%b%b want=00", bus2.busy, bus2.rsp_valid); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus2.req0_addr = 9'h050; bus2.req0_len = 9'd7; bus2.req0_valid = 1'b1;
      #1;
      total++; if (bus2.req0_ready !== 1'b1) begin bad++; $display("FAIL rstmid accept got=%b want=1", bus2.req0_ready); end
      @(negedge clk);
      bus2.req0_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      total++; if (bus2.ram_re !== 1'b1 || bus2.rsp_valid !== 1'b1) begin bad++; $display("FAIL rstmid pre re/valid got=%b%b want=11", bus2.ram_re, bus2.rsp_valid); end
      rst_n = 1'b0;
      #1;
      total++; if (bus2.ram_re !== 1'b0) begin bad++; $display("FAIL rstmid ram_re got=%b want=0", bus2.ram_re); end
      total++; if (bus2.rsp_valid !== 1'b0 || bus1.rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid rsp_valid got=%b%b want=00", bus2.rsp_valid, bus1.rsp_valid); end
      total++; if (bus2.busy !== 1'b0 || bus1.busy !== 1'b0) begin bad++; $display("FAIL rstmid busy got=%b%b want=00", bus2.busy, bus1.busy); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         total++; if (bus2.rsp_valid !== 1'b0 || bus2.ram_re !== 1'b0) begin bad++; $display("FAIL rstmid quiet c=%0d valid/re got=%b%b want=00", c, bus2.rsp_valid, bus2.ram_re); end
      end
      @(negedge clk);
      bus2.req0_addr = 9'h060; bus2.req0_len = 9'd0; bus2.req0_valid = 1'b1;
      bus2.req1_addr = 9'h070; bus2.req1_len = 9'd0; bus2.req1_valid = 1'b1;
      #1;
      total++; if ({bus2.req1_ready, bus2.req0_ready} !== 2'b01) begin bad++; $display("FAIL rstmid prio got=%b%b want=01", bus2.req1_ready, bus2.req0_ready); end
      @(negedge clk);
      bus2.req0_valid = 1'b0;
      #1;
      total++; if (bus2.ram_re !== 1'b1 || bus2.ram_raddr !== 9'h060) begin bad++; $display("FAIL rstmid req0 issue got=%b/%h want=1/060", bus2.ram_re, bus2.ram_raddr); end
      @(negedge clk);
      #1;
      total++; if ({bus2.req1_ready, bus2.req0_ready} !== 2'b10) begin bad++; $display("FAIL rstmid req1 grant got=%b%b want=10", bus2.req1_ready, bus2.req0_ready); end
      @(negedge clk);
      bus2.req1_valid = 1'b0;
      #1;
      total++; if (bus2.ram_re !== 1'b1 || bus2.ram_raddr !== 9'h070) begin bad++; $display("FAIL rstmid req1 issue got=%b/%h want=1/070", bus2.ram_re, bus2.ram_raddr); end
      repeat (4) @(negedge clk);
      #1;
      total++; if (bus2.busy !== 1'b0) begin bad++; $display("FAIL rstmid drain busy got=%b want=0", bus2.busy); end
   endtask

   initial begin
      rst_n = 1'b0;
      bus2.req0_valid = 1'b0; bus2.req0_addr = '0; bus2.req0_len = '0;
      bus2.req1_valid = 1'b0; bus2.req1_addr = '0; bus2.req1_len = '0;
      test_reset();
      test_single_burst();
      test_wrap();
      test_len_extremes();
      test_contention();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
